// File: rtl/ring_counter_decoder.sv
// Ring count bus checker: decodes the one-hot sample, checks hold/rotate rules, tracks lock.
// Optional saturating error counter is built when RING_DECODER_ERR_COUNT_EN is defined.
module ring_counter_decoder #(
    parameter int LOCK_COUNT    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     Clk_In,
    input  logic                     Reset_In,
    input  logic                     Enable_In,
    input  logic [3:0]               Ring_Value_In,
    input  logic                     Ring_Running_In,
    input  logic                     Clear_Errors_In,
    output logic [1:0]               Decoded_Index_Out,
    output logic                     Index_Valid_Out,
    output logic                     Lock_Flag_Out,
    output logic                     Error_Flag_Out,
    output logic [ERR_CNT_WIDTH-1:0] Error_Count_Out
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    localparam logic [3:0] LockTarget = 4'(LOCK_COUNT);

    state_t     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] good_q, good_d;
    logic [1:0] index_q, index_d;
    logic       valid_q, valid_d;
    logic       lock_q, lock_d;
    logic       errFlag_q, errFlag_d;

    logic       isOneHot;
    logic [1:0] decIdx;
    logic [3:0] expectedValue;
    logic       isLegal;
    logic       errHit;
    logic [ERR_CNT_WIDTH-1:0] errCntValue;

    always_comb begin
        isOneHot = 1'b0;
        decIdx   = 2'd0;
        case (Ring_Value_In)
            4'b0001: begin isOneHot = 1'b1; decIdx = 2'd0; end
            4'b0010: begin isOneHot = 1'b1; decIdx = 2'd1; end
            4'b0100: begin isOneHot = 1'b1; decIdx = 2'd2; end
            4'b1000: begin isOneHot = 1'b1; decIdx = 2'd3; end
            default: begin isOneHot = 1'b0; decIdx = 2'd0; end
        endcase
    end

    // A running ring must advance by exactly one rotate-left; a stopped ring must hold.
    assign expectedValue = Ring_Running_In ? {prev_q[2:0], prev_q[3]} : prev_q;
    assign isLegal       = isOneHot && (Ring_Value_In == expectedValue);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        errHit  = 1'b0;
        case (state_q)
            HUNT: begin
                if (isOneHot) begin
                    good_d  = 4'd1;
                    state_d = (LockTarget == 4'd1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (isLegal) begin
                    good_d = good_q + 4'd1;
                    if ((good_q + 4'd1) == LockTarget) begin
                        state_d = LOCKED;
                    end
                end else begin
                    errHit  = 1'b1;
                    good_d  = 4'd0;
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                if (!isLegal) begin
                    errHit  = 1'b1;
                    state_d = LOST;
                end
            end
            LOST: begin
                good_d  = 4'd0;
                state_d = HUNT;
            end
            default: begin
                good_d  = 4'd0;
                state_d = HUNT;
            end
        endcase
    end

    always_comb begin
        prev_d    = isOneHot ? Ring_Value_In : prev_q;
        index_d   = isOneHot ? decIdx : index_q;
        valid_d   = isOneHot;
        lock_d    = (state_d == LOCKED);
        // Clear acts before the error of the same edge, so a coincident error still sets the flag.
        errFlag_d = (Clear_Errors_In ? 1'b0 : errFlag_q) | errHit;
    end

    always_ff @(negedge Clk_In) begin
        if (Reset_In) begin
            state_q   <= HUNT;
            prev_q    <= 4'b0001;
            good_q    <= 4'd0;
            index_q   <= 2'd0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            errFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            good_q    <= good_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            errFlag_q <= errFlag_d;
        end
    end

`ifdef RING_DECODER_ERR_COUNT_EN
    logic [ERR_CNT_WIDTH-1:0] errCnt_q, errCnt_d, errCntBase;

    always_comb begin
        errCntBase = Clear_Errors_In ? '0 : errCnt_q;
        errCnt_d   = errCntBase;
        if (errHit && (errCntBase != {ERR_CNT_WIDTH{1'b1}})) begin
            errCnt_d = errCntBase + 1'b1;
        end
    end

    always_ff @(negedge Clk_In) begin
        if (Reset_In) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign errCntValue = errCnt_q;
`else
    assign errCntValue = '0;
`endif

    assign Decoded_Index_Out = Enable_In ? index_q     : 2'bzz;
    assign Index_Valid_Out   = Enable_In ? valid_q     : 1'bz;
    assign Lock_Flag_Out     = Enable_In ? lock_q      : 1'bz;
    assign Error_Flag_Out    = Enable_In ? errFlag_q   : 1'bz;
    assign Error_Count_Out   = Enable_In ? errCntValue : {ERR_CNT_WIDTH{1'bz}};

endmodule

// File: doc/ring_counter_decoder.md
# ring_counter_decoder

Receiving end of the 4-bit one-hot ring count bus. It samples the ring value and running flag produced by the ring counter, decodes the one-hot value to a 2-bit position index, and checks that the sequence obeys the ring rules (hold when stopped, rotate-left by one when running). A lock state machine reports when the stream is trusted. Error detection is sticky, and an optional saturating error counter can be compiled in.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive legal samples required to declare lock (range 1..15).
- ERR_CNT_WIDTH, 8: width of the error counter.

Ports:
- Clk_In  input  1  Single clock. All state updates occur on the falling edge.
- Reset_In  input  1  Synchronous, active-high reset, sampled on the falling edge of Clk_In.
- Enable_In  input  1  Output enable. When low, all outputs are high-Z. Internal logic keeps running.
- Ring_Value_In  input  4  Ring count bus under check.
- Ring_Running_In  input  1  Running flag that accompanies the ring bus.
- Clear_Errors_In  input  1  Clears the sticky error flag and the error counter.
- Decoded_Index_Out  output  2  Index of the set bit in the last sample.
- Index_Valid_Out  output  1  High when the last sample was exactly one-hot.
- Lock_Flag_Out  output  1  High while the state machine is in LOCKED.
- Error_Flag_Out  output  1  Sticky; set on any counted error.
- Error_Count_Out  output  ERR_CNT_WIDTH  Saturating count of counted errors.

## Operation
- **Decode:** 0001 maps to 0, 0010 to 1, 0100 to 2, 1000 to 3.
  - When the input is not one-hot (zero or multiple bits set), Index_Valid_Out goes to 0 and Decoded_Index_Out holds its previous value.
- **Previous-sample register** r_Prev: updated with every one-hot sample.
- **Legal sample** (used in CHECK and LOCKED): the input is one-hot AND
  - if Ring_Running_In = 1, input == {r_Prev[2:0], r_Prev[3]};
  - if Ring_Running_In = 0, input == r_Prev.
- **State machine states:** HUNT, CHECK, LOCKED, LOST.
- **Transitions:**
  - HUNT: a one-hot sample loads r_Prev, sets good count to 1, and moves to CHECK. With LOCK_COUNT = 1 it moves directly to LOCKED. A non-one-hot sample stays in HUNT and is not counted as an error.
  - CHECK: a legal sample increments the good count; the state moves to LOCKED when the count reaches LOCK_COUNT. An illegal sample is a counted error and returns to HUNT.
  - LOCKED: a legal sample stays in LOCKED. An illegal sample is a counted error and moves to LOST.
  - LOST: unconditionally moves to HUNT on the next edge. The sample taken in LOST is ignored.
- **Counted error effects:** Error_Flag_Out is set to 1 and the counter increments, saturating at 2^ERR_CNT_WIDTH − 1.
- **Simultaneous clear and error:** Clear_Errors_In has effect first, then the error is applied. Result: flag = 1, count = 1.
- **Clear with no error:** flag = 0, count = 0.

## Timing
- Latency is one falling edge from input sample to all outputs.
- Lock_Flag_Out rises on the edge where the LOCK_COUNT-th consecutive legal sample is taken, counting the HUNT acquisition sample as the first.
- Lock_Flag_Out falls on the edge that samples the first illegal value. The earliest possible relock is 1 (LOST) + LOCK_COUNT samples later.
- **Reset values:**
  - State = HUNT, r_Prev = 0001, good count = 0.
  - Decoded_Index_Out = 0, Index_Valid_Out = 0, Lock_Flag_Out = 0, Error_Flag_Out = 0, Error_Count_Out = 0.
- Reset asserted mid-operation overrides every input on that edge, including Clear_Errors_In and a pending error.
- Enable_In affects only the output drivers, combinationally. It has no cycle effect.

## Configuration
- **RING_DECODER_ERR_COUNT_EN defined:** the ERR_CNT_WIDTH saturating error counter is built and drives Error_Count_Out.
- **Macro undefined:** no counter logic is built. Error_Count_Out is driven constant 0 (high-Z when Enable_In = 0). Error_Flag_Out behaviour is unchanged.

## Test plan
- **Reset and acquisition:** Reset, then running samples 0001, 0010, 0100, 1000 → Decoded_Index_Out = 0, 1, 2, 3. Lock_Flag_Out = 1 after the 4th sample. Error_Count_Out = 0.
- **Hold while stopped:** While locked, Ring_Running_In = 0 and input held at 0100 for 10 edges → Lock_Flag_Out stays 1, no error, index = 2.
- **Skip and relock:** While locked and running, jump 0010 → 1000 → Lock_Flag_Out = 0, Error_Flag_Out = 1, Error_Count_Out = 1. State passes through LOST, then HUNT; relock after 4 further legal samples.
- **Illegal encodings:** In HUNT, inputs 0000 and 0110 → Index_Valid_Out = 0, no counted error. In LOCKED, input 0011 → error count increments and lock drops.
- **Clear and saturation:** With the macro defined and ERR_CNT_WIDTH = 2, force 5 errors → count saturates at 3. Clear_Errors_In asserted on the same edge as a new error → flag = 1, count = 1. Clear alone → 0, 0.
- **Enable and reset:** Enable_In = 0 → all outputs Z while state still advances; re-enable shows current lock. Assert Reset_In mid-lock → all outputs return to reset values on that edge.
